// File: rtl/skinny_round_ctrl.sv
// Round sequencer for the masked SKINNY-128-384+ round datapath.
// Paces each round over CPR randomness-gated cycles and strobes the registers.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, tk1_en    begin a block (sampled in IDLE), include TKZ for the run
//   rnd_valid        fresh randomness present this cycle
//   rnd_ready        randomness consumed this cycle (high in RUN)
//   busy, done       run in progress, one-cycle pulse after last round
//   round, constant  current round index and SKINNY round constant
//   *enc, *se        register update strobes, one pulse per completed round
//   tk1s             include TKZ in the round key
module skinny_round_ctrl #(
    parameter int ROUNDS = 40,
    parameter int CPR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       tk1_en,
    input  logic       rnd_valid,
    output logic       rnd_ready,
    output logic       busy,
    output logic       done,
    output logic [5:0] round,
    output logic [5:0] constant,
    output logic       senc,
    output logic       sse,
    output logic       xenc,
    output logic       xse,
    output logic       yenc,
    output logic       yse,
    output logic       zenc,
    output logic       zse,
    output logic       tk1s
);

    localparam int PW = (CPR > 1) ? $clog2(CPR) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(CPR - 1);
    localparam logic [5:0]    R_LAST  = 6'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [5:0]    round_q, round_d;
    logic [5:0]    const_q, const_d;
    logic          tk1s_q, tk1s_d;
    logic          round_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            round_q <= '0;
            const_q <= '0;
            tk1s_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            round_q <= round_d;
            const_q <= const_d;
            tk1s_q  <= tk1s_d;
        end
    end

    // A round completes on the last phase, but only when randomness is
    // actually present; a stalled cycle never advances or strobes.
    assign round_end = (state_q == RUN) && rnd_valid && (phase_q == PH_LAST);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        round_d = round_q;
        const_d = const_q;
        tk1s_d  = tk1s_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    phase_d = '0;
                    round_d = '0;
                    const_d = 6'h01;
                    tk1s_d  = tk1_en;
                end
            end
            RUN: begin
                if (rnd_valid) begin
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        if (round_q == R_LAST) begin
                            // round and constant keep their final values
                            state_d = FIN;
                            tk1s_d  = 1'b0;
                        end else begin
                            round_d = round_q + 6'd1;
                            const_d = {const_q[4:0],
                                       ~(const_q[5] ^ const_q[4])};
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q == RUN);
    assign rnd_ready = (state_q == RUN);
    assign done      = (state_q == FIN);
    assign round     = round_q;
    assign constant  = const_q;
    assign tk1s      = tk1s_q;

    // se=1 selects the SKINNY round path in the mode top
    assign senc = round_end;
    assign sse  = round_end;
    assign xenc = round_end;
    assign xse  = round_end;
    assign yenc = round_end;
    assign yse  = round_end;
    assign zenc = round_end;
    assign zse  = round_end;

endmodule
